// File: rtl/regmask_pkg.sv
// Shared types and sizing for the register-mask encoder.
package regmask_pkg;

    localparam int N_REGS = 32;
    localparam int IDX_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    typedef logic [IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/regmask_encoder_if.sv
// Load/index handshake bundle between pipeline control and the port sequencer.
interface regmask_encoder_if;
    import regmask_pkg::*;

    logic              load_valid;
    logic              load_ready;
    logic [N_REGS-1:0] load_vec;
    logic              flush;
    logic              idx_valid;
    logic              idx_ready;
    reg_idx_t          idx;
    logic              idx_last;
    logic              done;
    logic [IDX_W:0]    emit_cnt;

    modport master (
        output load_valid, load_vec, flush, idx_ready,
        input  load_ready, idx_valid, idx, idx_last, done, emit_cnt
    );

    modport slave (
        input  load_valid, load_vec, flush, idx_ready,
        output load_ready, idx_valid, idx, idx_last, done, emit_cnt
    );

endinterface

// File: rtl/regmask_encoder_prio_enc32.sv
// Lowest-set-bit encoder for a 32-bit mask: four 8-bit group encoders
// followed by a 4-way group select, the inverse of the 2-to-4 / 3-to-8 decode.
module prio_enc32
    import regmask_pkg::*;
(
    input  logic [N_REGS-1:0] vec,
    output reg_idx_t          idx,
    output logic              any,
    output logic              onehot_exact
);

    logic [3:0] grp_any;
    logic [2:0] grp_lo [4];

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            grp_any[g] = |vec[g*8 +: 8];
            grp_lo[g]  = 3'd0;
            // Scan high to low so the lowest set bit wins.
            for (int b = 7; b >= 0; b--) begin
                if (vec[g*8 + b]) grp_lo[g] = 3'(b);
            end
        end
    end

    always_comb begin
        idx = '0;
        casez (grp_any)
            4'b???1: idx = {2'd0, grp_lo[0]};
            4'b??10: idx = {2'd1, grp_lo[1]};
            4'b?100: idx = {2'd2, grp_lo[2]};
            4'b1000: idx = {2'd3, grp_lo[3]};
            default: idx = '0;
        endcase
    end

    assign any          = |grp_any;
    assign onehot_exact = any && ((vec & (vec - {{(N_REGS-1){1'b0}}, 1'b1})) == '0);

endmodule

// File: rtl/regmask_encoder.sv
// Sequential mask-to-index encoder: emits each set bit of a loaded register
// mask, lowest first, one per valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for a mask, load_ready high
// SCAN  | presenting lowest pending index on idx
// DONE  | one-cycle done pulse, then back to IDLE
module regmask_encoder
    import regmask_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    regmask_encoder_if.slave   bus
);

    enc_state_t        state_q, state_d;
    logic [N_REGS-1:0] pend_q, pend_d;
    logic [IDX_W:0]    cnt_q, cnt_d;

    reg_idx_t          enc_idx;
    logic              enc_any;
    logic              enc_single;
    logic [N_REGS-1:0] idx_bit;

    prio_enc32 u_prio (
        .vec          (pend_q),
        .idx          (enc_idx),
        .any          (enc_any),
        .onehot_exact (enc_single)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        idx_bit          = '0;
        idx_bit[enc_idx] = 1'b1;
    end

    always_comb begin
        state_d        = state_q;
        pend_d         = pend_q;
        cnt_d          = cnt_q;
        bus.load_ready = 1'b0;
        bus.idx_valid  = 1'b0;
        bus.idx        = '0;
        bus.idx_last   = 1'b0;
        bus.done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.load_ready = 1'b1;
                if (bus.load_valid) begin
                    pend_d  = bus.load_vec;
                    cnt_d   = '0;
                    state_d = (bus.load_vec != '0) ? SCAN : DONE;
                end
            end
            SCAN: begin
                bus.idx_valid = 1'b1;
                bus.idx       = enc_idx;
                bus.idx_last  = enc_single;
                // Flush wins over a same-cycle handshake and suppresses done.
                if (bus.flush) begin
                    pend_d  = '0;
                    state_d = IDLE;
                end else if (bus.idx_ready) begin
                    pend_d = pend_q & ~idx_bit;
                    cnt_d  = cnt_q + (IDX_W+1)'(1);
                    if (enc_single) state_d = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                pend_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign bus.emit_cnt = cnt_q;

`ifndef SYNTHESIS
    logic [IDX_W:0] loaded_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            loaded_pop <= '0;
        else if (state_q == IDLE && bus.load_valid)
            loaded_pop <= (IDX_W+1)'($countones(bus.load_vec));
    end

    a_valid_has_pend: assert property (@(posedge clk) disable iff (reset)
        bus.idx_valid |-> enc_any);

    a_pop_conserved: assert property (@(posedge clk) disable iff (reset)
        (state_q == SCAN) |-> ($countones(pend_q) + int'(cnt_q) == int'(loaded_pop)));
`endif

endmodule

// File: tb/tb_regmask_encoder.sv
// Self-checking bench for regmask_encoder against a set-bit-list reference model.
module tb_regmask_encoder;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    regmask_encoder_if bus ();

    regmask_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: ascending list of set-bit positions of a mask.
    task automatic model_bits(input logic [31:0] m, output int q[$]);
        q = {};
        for (int i = 0; i < 32; i++)
            if (m[i]) q.push_back(i);
    endtask

    // Offer a mask from a negedge; returns at the first negedge after acceptance.
    task automatic load_mask(input logic [31:0] m);
        int guard;
        guard = 0;
        while (bus.load_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        bus.load_valid = 1'b1;
        bus.load_vec   = m;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.load_vec   = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL rst_load_ready got=%0b exp=1", bus.load_ready); end
        checks++; if (bus.idx_valid !== 1'b0) begin errors++; $display("FAIL rst_idx_valid got=%0b exp=0", bus.idx_valid); end
        checks++; if (bus.idx !== 5'd0) begin errors++; $display("FAIL rst_idx got=%0d exp=0", bus.idx); end
        checks++; if (bus.done !== 1'b0 || bus.idx_last !== 1'b0) begin errors++; $display("FAIL rst_done_last got=%0b%0b exp=00", bus.done, bus.idx_last); end
        checks++; if (bus.emit_cnt !== 6'd0) begin errors++; $display("FAIL rst_emit_cnt got=%0d exp=0", bus.emit_cnt); end

        load_mask(32'h0000_00F0);
        checks++; if (bus.idx !== 5'd4) begin errors++; $display("FAIL rstmid_first_idx got=%0d exp=4", bus.idx); end
        bus.idx_ready = 1'b1;
        @(negedge clk);
        bus.idx_ready = 1'b0;
        checks++; if (bus.idx !== 5'd5 || bus.emit_cnt !== 6'd1) begin errors++; $display("FAIL rstmid_second got idx=%0d cnt=%0d exp idx=5 cnt=1", bus.idx, bus.emit_cnt); end
        reset = 1'b1;
        #1;
        checks++; if (bus.load_ready !== 1'b1 || bus.idx_valid !== 1'b0 || bus.idx !== 5'd0 || bus.idx_last !== 1'b0 || bus.done !== 1'b0)
            begin errors++; $display("FAIL rstmid_outputs got rdy=%0b vld=%0b idx=%0d last=%0b done=%0b exp 1 0 0 0 0", bus.load_ready, bus.idx_valid, bus.idx, bus.idx_last, bus.done); end
        checks++; if (bus.emit_cnt !== 6'd0) begin errors++; $display("FAIL rstmid_emit_cnt got=%0d exp=0", bus.emit_cnt); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        load_mask(32'h0000_0003);
        checks++; if (bus.idx_valid !== 1'b1 || bus.idx !== 5'd0 || bus.idx_last !== 1'b0)
            begin errors++; $display("FAIL postrst_load got vld=%0b idx=%0d last=%0b exp 1 0 0", bus.idx_valid, bus.idx, bus.idx_last); end
        bus.idx_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.idx !== 5'd1 || bus.idx_last !== 1'b1) begin errors++; $display("FAIL postrst_second got idx=%0d last=%0b exp 1 1", bus.idx, bus.idx_last); end
        @(negedge clk);
        bus.idx_ready = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.emit_cnt !== 6'd2) begin errors++; $display("FAIL postrst_done got done=%0b cnt=%0d exp 1 2", bus.done, bus.emit_cnt); end
        @(negedge clk);
    endtask

    task automatic test_sparse();
        int q[$];
        model_bits(32'h8000_0011, q);
        load_mask(32'h8000_0011);
        bus.idx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus.idx_valid !== 1'b1 || bus.idx !== 5'(q[k]) || bus.idx_last !== (k == 2))
                begin errors++; $display("FAIL sparse_idx%0d got vld=%0b idx=%0d last=%0b exp 1 %0d %0b", k, bus.idx_valid, bus.idx, bus.idx_last, q[k], k == 2); end
            @(negedge clk);
        end
        bus.idx_ready = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.idx_valid !== 1'b0 || bus.emit_cnt !== 6'd3)
            begin errors++; $display("FAIL sparse_done got done=%0b vld=%0b cnt=%0d exp 1 0 3", bus.done, bus.idx_valid, bus.emit_cnt); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.load_ready !== 1'b1 || bus.emit_cnt !== 6'd3)
            begin errors++; $display("FAIL sparse_idle got done=%0b rdy=%0b cnt=%0d exp 0 1 3", bus.done, bus.load_ready, bus.emit_cnt); end
    endtask

    task automatic test_backpressure();
        load_mask(32'h0000_0006);
        bus.idx_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (bus.idx_valid !== 1'b1 || bus.idx !== 5'd1 || bus.idx_last !== 1'b0 || bus.emit_cnt !== 6'd0)
                begin errors++; $display("FAIL bp_hold%0d got vld=%0b idx=%0d last=%0b cnt=%0d exp 1 1 0 0", c, bus.idx_valid, bus.idx, bus.idx_last, bus.emit_cnt); end
            @(negedge clk);
        end
        bus.idx_ready = 1'b1;
        checks++; if (bus.idx !== 5'd1) begin errors++; $display("FAIL bp_first got=%0d exp=1", bus.idx); end
        @(negedge clk);
        checks++; if (bus.idx !== 5'd2 || bus.idx_last !== 1'b1 || bus.done !== 1'b0)
            begin errors++; $display("FAIL bp_second got idx=%0d last=%0b done=%0b exp 2 1 0", bus.idx, bus.idx_last, bus.done); end
        @(negedge clk);
        bus.idx_ready = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.emit_cnt !== 6'd2) begin errors++; $display("FAIL bp_done got done=%0b cnt=%0d exp 1 2", bus.done, bus.emit_cnt); end
        @(negedge clk);
    endtask

    task automatic test_empty();
        load_mask(32'h0);
        checks++; if (bus.done !== 1'b1 || bus.idx_valid !== 1'b0 || bus.load_ready !== 1'b0 || bus.emit_cnt !== 6'd0)
            begin errors++; $display("FAIL empty_done got done=%0b vld=%0b rdy=%0b cnt=%0d exp 1 0 0 0", bus.done, bus.idx_valid, bus.load_ready, bus.emit_cnt); end
        @(negedge clk);
        checks++; if (bus.load_ready !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL empty_idle got rdy=%0b done=%0b exp 1 0", bus.load_ready, bus.done); end
    endtask

    task automatic test_full();
        int n_done;
        load_mask(32'hFFFF_FFFF);
        bus.idx_ready = 1'b1;
        n_done = 0;
        for (int k = 0; k < 32; k++) begin
            if (bus.done === 1'b1) n_done++;
            checks++; if (bus.idx_valid !== 1'b1 || bus.idx !== 5'(k) || bus.idx_last !== (k == 31))
                begin errors++; $display("FAIL full_idx%0d got vld=%0b idx=%0d last=%0b exp 1 %0d %0b", k, bus.idx_valid, bus.idx, bus.idx_last, k, k == 31); end
            @(negedge clk);
        end
        bus.idx_ready = 1'b0;
        checks++; if (bus.done !== 1'b1 || bus.emit_cnt !== 6'd32) begin errors++; $display("FAIL full_done got done=%0b cnt=%0d exp 1 32", bus.done, bus.emit_cnt); end
        @(negedge clk);
        if (bus.done === 1'b1) n_done++;
        checks++; if (n_done !== 0) begin errors++; $display("FAIL full_done_once got extra=%0d exp=0", n_done); end
    endtask

    task automatic test_flush();
        load_mask(32'h0000_0F00);
        bus.idx_ready = 1'b1;
        checks++; if (bus.idx !== 5'd8) begin errors++; $display("FAIL flush_first got=%0d exp=8", bus.idx); end
        @(negedge clk);
        checks++; if (bus.idx !== 5'd9) begin errors++; $display("FAIL flush_second got=%0d exp=9", bus.idx); end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.idx_ready = 1'b0;
        checks++; if (bus.load_ready !== 1'b1 || bus.idx_valid !== 1'b0 || bus.done !== 1'b0 || bus.emit_cnt !== 6'd1)
            begin errors++; $display("FAIL flush_idle got rdy=%0b vld=%0b done=%0b cnt=%0d exp 1 0 0 1", bus.load_ready, bus.idx_valid, bus.done, bus.emit_cnt); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0 || bus.load_ready !== 1'b1) begin errors++; $display("FAIL flush_nodone got done=%0b rdy=%0b exp 0 1", bus.done, bus.load_ready); end
        // Flush outside SCAN has no effect on the next load.
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        load_mask(32'h0000_0020);
        checks++; if (bus.idx_valid !== 1'b1 || bus.idx !== 5'd5 || bus.idx_last !== 1'b1)
            begin errors++; $display("FAIL flush_idle_ignored got vld=%0b idx=%0d last=%0b exp 1 5 1", bus.idx_valid, bus.idx, bus.idx_last); end
        bus.idx_ready = 1'b1;
        @(negedge clk);
        bus.idx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int          q[$];
        int          total;
        int          guard;
        logic [31:0] m;
        logic        rdy;
        for (int t = 0; t < 25; t++) begin
            case ($urandom_range(0, 3))
                0:       m = $urandom() & $urandom() & $urandom();
                1:       m = $urandom();
                2:       m = 32'h1 << $urandom_range(0, 31);
                default: m = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom() | $urandom());
            endcase
            model_bits(m, q);
            total = q.size();
            load_mask(m);
            guard = 0;
            while (q.size() > 0 && guard < 400) begin
                checks++; if (bus.idx_valid !== 1'b1 || bus.idx !== 5'(q[0]) || bus.idx_last !== (q.size() == 1) || bus.emit_cnt !== 6'(total - q.size()))
                    begin errors++; $display("FAIL rand%0d_idx got vld=%0b idx=%0d last=%0b cnt=%0d exp 1 %0d %0b %0d", t, bus.idx_valid, bus.idx, bus.idx_last, bus.emit_cnt, q[0], q.size() == 1, total - q.size()); end
                rdy = ($urandom_range(0, 9) < 7);
                bus.idx_ready = rdy;
                if (rdy) void'(q.pop_front());
                @(negedge clk);
                guard++;
            end
            bus.idx_ready = 1'b0;
            checks++; if (guard >= 400) begin errors++; $display("FAIL rand%0d_timeout got remaining=%0d exp=0", t, q.size()); end
            checks++; if (bus.done !== 1'b1 || bus.idx_valid !== 1'b0 || bus.emit_cnt !== 6'(total))
                begin errors++; $display("FAIL rand%0d_done got done=%0b vld=%0b cnt=%0d exp 1 0 %0d", t, bus.done, bus.idx_valid, bus.emit_cnt, total); end
            @(negedge clk);
        end
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_vec   = '0;
        bus.flush      = 1'b0;
        bus.idx_ready  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_sparse();
        test_backpressure();
        test_empty();
        test_full();
        test_flush();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
